dm_cache_wb_buffer: RTL and testbench
=====================================

# dm_cache_wb_buffer

Write-back buffer downstream of the direct-mapped cache data array. When the controller evicts a dirty line, it pushes the line here: tag, index and the 128-bit line from the data array read port. The buffer queues it in FIFO order and drains each line to main memory through a valid/ready handshake, so a refill can proceed without waiting for the write-back. It optionally forwards buffered lines to the controller on a read miss.

## Interface
Parameters:
- DEPTH, 4, number of line entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- evict_valid  in  1  controller offers an evicted dirty line.
- evict_ready  out  1  buffer can accept; equals !full.
- evict_tag  in  18  tag of evicted line.
- evict_index  in  10  cache index of evicted line.
- evict_data  in  128  line data (cache_data_type).
- mem_req_valid  out  1  write request to memory pending.
- mem_req_addr  out  32  byte address of line: {tag, index, 4'b0}.
- mem_req_data  out  128  line data of head entry.
- mem_req_ready  in  1  memory accepts the write this cycle.
- lookup_tag  in  18  read-miss probe tag.
- lookup_index  in  10  read-miss probe index.
- lookup_hit  out  1  probe matches a buffered line.
- lookup_data  out  128  data of the matching line.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.

## Operation
- Storage is a circular FIFO of DEPTH entries, each {tag, index, data}, with write pointer, read pointer and count.
- Push happens when evict_valid && evict_ready at a rising edge. The entry is written at the write pointer, the pointer increments modulo DEPTH, and count increments.
- evict_ready = (count != DEPTH). It does not depend on a same-cycle pop, so a full buffer refuses a push even in the cycle it drains.
- Drain FSM:
  - IDLE: mem_req_valid = 0. Go to REQ on the next edge if count != 0.
  - REQ: mem_req_valid = 1. mem_req_addr and mem_req_data come from the head entry.
  - The request is accepted at an edge where mem_req_valid && mem_req_ready. On accept, the head is popped and the read pointer increments modulo DEPTH.
  - After accept, stay in REQ if entries remain (count after pop, including any same-edge push, is nonzero); otherwise go to IDLE.
- Once mem_req_valid rises, addr and data stay stable until accepted. The valid is never withdrawn without acceptance, except by reset.
- Simultaneous push and pop leaves count unchanged and advances both pointers.
- Duplicate addresses are allowed (no coalescing). They drain in push order.
- Forwarding (see Configuration): combinational compare of lookup_tag/lookup_index against all valid entries.
  - With several matches, the youngest (most recently pushed) entry wins.
  - The head entry being drained in the same cycle still matches.
  - lookup_data is 0 when there is no hit.

## Timing
- Reset (rst_n low, asynchronous) clears pointers and count to 0 and forces the FSM to IDLE. It applies immediately, mid-transfer included.
  - Outputs while and after reset: mem_req_valid=0, evict_ready=1, empty=1, count=0, lookup_hit=0, mem_req_addr=0, mem_req_data=0.
  - Entries pending at reset are discarded.
- Push at edge N is visible in count/empty after edge N. The FSM leaves IDLE at edge N+1, so mem_req_valid is first high in the cycle after edge N+1 (2-edge latency from push into an empty buffer).
- Back-to-back accepts with mem_req_ready held high drain one line per cycle, with no bubble while count stays nonzero.
- Forwarding has zero-cycle latency. A push at edge N is matchable in the cycle after edge N.

## Configuration
- WB_FWD_EN defined: lookup compare logic is built as described above.
- WB_FWD_EN undefined:
  - lookup_hit tied 0 and lookup_data tied 0.
  - lookup_tag and lookup_index are ignored.
  - The port list is unchanged.

## Structure
- The cache_def package gains:
  - wb_entry_type struct {tag 18, index 10, data cache_data_type}.
  - localparam WB_DEPTH_DEFAULT = 4.
  - LINE_OFFSET_W = 4.
- Storage, pointers, count and the drain FSM live in this module. The FSM state enum is local to the module.
- One sub-module is natural: dm_cache_wb_match, the youngest-match priority comparator over entries plus valid mask. It is instantiated only under WB_FWD_EN.

## Test plan
- Reset mid-transfer:
  - Stimulus: push one line, hold mem_req_ready=0 until mem_req_valid=1, then pulse rst_n low.
  - Required: mem_req_valid drops immediately; count=0, evict_ready=1.
- Single line:
  - Stimulus: push tag=0x12345, index=0x3FF, data=0xA5..A5 into an empty buffer.
  - Required: mem_req_valid high 2 edges later, mem_req_addr=0x48D1_7FF0, data matches; after accept, empty=1 and FSM back in IDLE.
- Fill to full (DEPTH=4), mem_req_ready=0:
  - Stimulus: 4 pushes, then a 5th offered.
  - Required: evict_ready=0 and the 5th is not taken. With ready then held high, 4 accepts occur on consecutive edges, in push order.
- Full with simultaneous push and pop:
  - Stimulus: buffer full, evict_valid=1 and mem_req_ready=1 in the same cycle.
  - Required: pop only; count goes 4→3; the next cycle the push is accepted.
- Forwarding (WB_FWD_EN):
  - Stimulus: push the same tag/index twice with data 0x1 then 0x2; probe that address.
  - Required: lookup_hit=1, lookup_data=0x2. A probe of an absent address gives lookup_hit=0.
- Pointer wrap:
  - Stimulus: 10 pushes interleaved with accepts, DEPTH=4.
  - Required: all 10 lines appear on mem_req in push order with correct addresses; count never exceeds 4.

Source files
------------

// File: rtl/cache_def.sv
// Shared cache definitions: line data type, tag/index widths and the
// write-back buffer entry layout.
package cache_def;

  localparam int TAG_W            = 18;
  localparam int INDEX_W          = 10;
  localparam int LINE_OFFSET_W    = 4;
  localparam int WB_DEPTH_DEFAULT = 4;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    cache_data_type     data;
  } wb_entry_type;

  localparam int WB_ENTRY_W = $bits(wb_entry_type);

endpackage

// File: rtl/dm_cache_wb_match.sv
// Youngest-match comparator over the write-back buffer entries; walks entries
// from head (oldest) to tail so the last valid match, the youngest, wins.
module dm_cache_wb_match
  import cache_def::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WB_ENTRY_W-1:0] entries_i,
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [PTR_W-1:0]                 rd_ptr_i,
  input  logic [TAG_W-1:0]                 tag_i,
  input  logic [INDEX_W-1:0]               index_i,
  output logic                             hit_o,
  output logic [127:0]                     data_o
);

  logic [PTR_W-1:0] idx;
  wb_entry_type     e;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    e      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + PTR_W'(k);
      e   = wb_entry_type'(entries_i[idx]);
      if (valid_i[idx] && (e.tag == tag_i) && (e.index == index_i)) begin
        hit_o  = 1'b1;
        data_o = e.data;
      end
    end
  end

endmodule

// File: rtl/dm_cache_wb_buffer.sv
// Write-back buffer: FIFO of evicted dirty lines drained to memory over a
// valid/ready handshake. Define WB_FWD_EN to build read-miss forwarding.
module dm_cache_wb_buffer
  import cache_def::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     evict_valid,
  output logic                     evict_ready,
  input  logic [17:0]              evict_tag,
  input  logic [9:0]               evict_index,
  input  logic [127:0]             evict_data,
  output logic                     mem_req_valid,
  output logic [31:0]              mem_req_addr,
  output logic [127:0]             mem_req_data,
  input  logic                     mem_req_ready,
  input  logic [17:0]              lookup_tag,
  input  logic [9:0]               lookup_index,
  output logic                     lookup_hit,
  output logic [127:0]             lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e                          state_q, state_d;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [DEPTH-1:0][WB_ENTRY_W-1:0] mem_q;
  wb_entry_type                    head;
  wb_entry_type                    wr_entry;
  logic                            push, pop;

  assign evict_ready = (count_q != CNT_W'(DEPTH));
  assign push        = evict_valid && evict_ready;
  assign pop         = (state_q == REQ) && mem_req_ready;
  assign head        = wb_entry_type'(mem_q[rd_ptr_q]);
  assign count       = count_q;
  assign empty       = (count_q == '0);

  assign wr_entry.tag   = evict_tag;
  assign wr_entry.index = evict_index;
  assign wr_entry.data  = evict_data;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Address/data are gated by REQ so stale storage never leaks out after reset.
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {head.tag, head.index, {LINE_OFFSET_W{1'b0}}};
        mem_req_data  = head.data;
        if (pop && (count_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Line storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

`ifdef WB_FWD_EN
  logic [DEPTH-1:0] valid_mask;
  logic [PTR_W-1:0] age;

  always_comb begin
    valid_mask = '0;
    age        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age           = PTR_W'(i) - rd_ptr_q;
      valid_mask[i] = ({1'b0, age} < count_q);
    end
  end

  dm_cache_wb_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .entries_i (mem_q),
    .valid_i   (valid_mask),
    .rd_ptr_i  (rd_ptr_q),
    .tag_i     (lookup_tag),
    .index_i   (lookup_index),
    .hit_o     (lookup_hit),
    .data_o    (lookup_data)
  );
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookup_tag, lookup_index};
  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_dm_cache_wb_buffer.sv
// Scoreboard bench for dm_cache_wb_buffer: stimulus queues expected drains,
// a negedge monitor checks every accepted memory write in order.
module tb_dm_cache_wb_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         evict_valid;
  logic         evict_ready;
  logic [17:0]  evict_tag;
  logic [9:0]   evict_index;
  logic [127:0] evict_data;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_ready;
  logic [17:0]  lookup_tag;
  logic [9:0]   lookup_index;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic [2:0]   count;
  logic         empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [159:0] expq[$];

  always #5 clk = ~clk;

  dm_cache_wb_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_tag(evict_tag), .evict_index(evict_index), .evict_data(evict_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .lookup_tag(lookup_tag), .lookup_index(lookup_index),
    .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count), .empty(empty)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input logic [17:0] t, input logic [9:0] i);
    return {t, i, 4'b0000};
  endfunction

  task automatic drive_evict(input logic [17:0] t, input logic [9:0] i, input logic [127:0] d);
    evict_valid = 1'b1;
    evict_tag   = t;
    evict_index = i;
    evict_data  = d;
  endtask

  // Monitor: an accept happens at the next rising edge when valid&&ready here.
  always @(negedge clk) begin
    logic [159:0] e;
    if (rst_n && mem_req_valid && mem_req_ready) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_drain: got addr %h with no expected entry", mem_req_addr);
      end else begin
        e = expq.pop_front();
        check("drain_addr", {96'b0, mem_req_addr}, {96'b0, e[159:128]});
        check("drain_data", mem_req_data, e[127:0]);
      end
    end
  end

  initial begin
    int pushed;
    int waited;
    rst_n = 1'b0; evict_valid = 1'b0; evict_tag = '0; evict_index = '0; evict_data = '0;
    mem_req_ready = 1'b0; lookup_tag = '0; lookup_index = '0;
    #3;
    check("rst_valid", {127'b0, mem_req_valid}, 128'd0);
    check("rst_ready", {127'b0, evict_ready}, 128'd1);
    check("rst_empty", {127'b0, empty}, 128'd1);
    check("rst_count", {125'b0, count}, 128'd0);
    check("rst_hit",   {127'b0, lookup_hit}, 128'd0);
    check("rst_addr",  {96'b0, mem_req_addr}, 128'd0);
    check("rst_data",  mem_req_data, 128'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single line: 2-edge latency, address formation, return to idle.
    drive_evict(18'h12345, 10'h3FF, {16{8'hA5}});
    expq.push_back({32'h48D1_7FF0, {16{8'hA5}}});
    tick();
    evict_valid = 1'b0;
    check("single_count", {125'b0, count}, 128'd1);
    check("single_not_empty", {127'b0, empty}, 128'd0);
    check("single_valid_lat1", {127'b0, mem_req_valid}, 128'd0);
    tick();
    check("single_valid_lat2", {127'b0, mem_req_valid}, 128'd1);
    check("single_addr", {96'b0, mem_req_addr}, 128'h48D1_7FF0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("single_empty_after", {127'b0, empty}, 128'd1);
    check("single_idle_after", {127'b0, mem_req_valid}, 128'd0);

    // Fill to full, refuse a fifth, then full with push+pop in one cycle.
    for (int i = 1; i <= 4; i++) begin
      drive_evict(18'(i), 10'(i * 5), {4{32'hD000_0000 + 32'(i)}});
      expq.push_back({mk_addr(18'(i), 10'(i * 5)), {4{32'hD000_0000 + 32'(i)}}});
      tick();
    end
    check("full_count", {125'b0, count}, 128'd4);
    check("full_ready_low", {127'b0, evict_ready}, 128'd0);
    drive_evict(18'h5, 10'h55, {4{32'hD000_0005}});
    expq.push_back({mk_addr(18'h5, 10'h55), {4{32'hD000_0005}}});
    tick();
    check("fifth_refused", {125'b0, count}, 128'd4);
    check("full_valid", {127'b0, mem_req_valid}, 128'd1);
    mem_req_ready = 1'b1;
    tick();
    check("full_pushpop_pop_only", {125'b0, count}, 128'd3);
    check("full_ready_back", {127'b0, evict_ready}, 128'd1);
    tick();
    evict_valid = 1'b0;
    check("push_after_pop", {125'b0, count}, 128'd3);
    for (int k = 2; k >= 0; k--) begin
      check("b2b_valid", {127'b0, mem_req_valid}, 128'd1);
      tick();
      check("b2b_count", {125'b0, count}, 128'(k));
    end
    mem_req_ready = 1'b0;
    check("b2b_drained_idle", {127'b0, mem_req_valid}, 128'd0);
    check("b2b_scoreboard_empty", 128'(expq.size()), 128'd0);

    // Forwarding: duplicates, youngest wins; absent address misses.
    drive_evict(18'h2AAAA, 10'h155, 128'h1);
    expq.push_back({mk_addr(18'h2AAAA, 10'h155), 128'h1});
    tick();
    drive_evict(18'h2AAAA, 10'h155, 128'h2);
    expq.push_back({mk_addr(18'h2AAAA, 10'h155), 128'h2});
    tick();
    evict_valid = 1'b0;
    lookup_tag = 18'h2AAAA; lookup_index = 10'h155;
    #1;
`ifdef WB_FWD_EN
    check("fwd_hit", {127'b0, lookup_hit}, 128'd1);
    check("fwd_youngest_data", lookup_data, 128'h2);
`else
    check("fwd_off_hit", {127'b0, lookup_hit}, 128'd0);
    check("fwd_off_data", lookup_data, 128'd0);
`endif
    lookup_tag = 18'h0BEEF; lookup_index = 10'h001;
    #1;
    check("fwd_miss_hit", {127'b0, lookup_hit}, 128'd0);
    check("fwd_miss_data", lookup_data, 128'd0);
    mem_req_ready = 1'b1;
    waited = 0;
    while (!empty && waited < 20) begin
      tick();
      waited++;
    end
    if (!empty) check("fwd_drain_timeout", 128'd0, 128'd1);
    mem_req_ready = 1'b0;
    tick();

    // Reset mid-transfer: valid drops at once, pending line discarded.
    drive_evict(18'h3FFFF, 10'h2A, 128'hDEAD);
    tick();
    evict_valid = 1'b0;
    tick();
    check("mid_valid_before_rst", {127'b0, mem_req_valid}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {127'b0, mem_req_valid}, 128'd0);
    check("mid_rst_count", {125'b0, count}, 128'd0);
    check("mid_rst_ready", {127'b0, evict_ready}, 128'd1);
    check("mid_rst_addr", {96'b0, mem_req_addr}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_after_rst_valid", {127'b0, mem_req_valid}, 128'd0);

    // Pointer wrap: 10 pushes interleaved with irregular accepts.
    pushed = 0;
    for (int cyc = 0; cyc < 200 && !(pushed == 10 && empty && expq.size() == 0); cyc++) begin
      mem_req_ready = (cyc % 3 != 1);
      if (pushed < 10) begin
        drive_evict(18'h100 + 18'(pushed), 10'(pushed * 37), {4{32'hC0DE_0000 + 32'(pushed)}});
        if (evict_ready) begin
          expq.push_back({mk_addr(18'h100 + 18'(pushed), 10'(pushed * 37)),
                          {4{32'hC0DE_0000 + 32'(pushed)}}});
          pushed++;
        end
      end else begin
        evict_valid = 1'b0;
      end
      tick();
      check("wrap_count_le_depth", {127'b0, (count <= 3'd4)}, 128'd1);
    end
    evict_valid = 1'b0;
    mem_req_ready = 1'b0;
    check("wrap_all_pushed", 128'(pushed), 128'd10);
    check("wrap_all_drained", 128'(expq.size()), 128'd0);
    check("wrap_empty", {127'b0, empty}, 128'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
